// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed-latency, in-order response pipeline and backpressure.
// Define DMEM_MISALIGN_CHECK_EN to add resp_err and block misaligned accesses.
package data_mem_resp_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
        logic              MemWrite;
        logic              MemRead;
        logic              valid;
    } memReqStruct;

    typedef struct packed {
        logic [DATA_W-1:0] rd_data;
        logic              MemWrite;
        logic              MemRead;
        logic              valid;
    } memRespStruct;
endpackage

module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  memReqStruct  req,
    output logic         req_ready,
    output memRespStruct resp,
    input  logic         resp_ready
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic         resp_err
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd_data;
        logic              MemWrite;
        logic              MemRead;
        logic              err;
    } stage_t;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    stage_t            pipe_q [LATENCY];
    stage_t            pipe_d [LATENCY];
    stage_t            acc_stage;
    logic [IDX_W-1:0]  idx;
    logic              stall;
    logic              accept;
    logic              misalign;
    logic              mem_we;
    logic              unused_addr;

    assign idx         = req.addr[IDX_W+1:2];
    assign unused_addr = ^{req.addr[ADDR_W-1:IDX_W+2], req.addr[1:0]};

    // A held response at the output freezes every stage and blocks new requests.
    assign stall     = pipe_q[LATENCY-1].valid & ~resp_ready;
    assign req_ready = ~stall;
    assign accept    = req.valid & ~stall & ~reset;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (req.addr[1:0] != 2'b00) & (req.MemWrite | req.MemRead);
    assign resp_err = pipe_q[LATENCY-1].err;
`else
    logic unused_err;
    assign misalign   = 1'b0;
    assign unused_err = pipe_q[LATENCY-1].err;
`endif

    assign mem_we = accept & req.MemWrite & ~misalign;

    // Entry captured at acceptance; loads read here and carry the data down the pipe.
    always_comb begin
        acc_stage = '0;
        if (accept) begin
            acc_stage.valid    = 1'b1;
            acc_stage.MemWrite = req.MemWrite;
            acc_stage.MemRead  = req.MemRead;
            acc_stage.err      = misalign;
            if (req.MemRead && !req.MemWrite && !misalign) begin
                acc_stage.rd_data = mem_q[idx];
            end
        end
    end

    // Stages shift uniformly; empty stages shift too, so latency never depends on occupancy.
    always_comb begin
        pipe_d = pipe_q;
        if (!stall) begin
            pipe_d[0] = acc_stage;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Storage is intentionally not reset so contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= req.wr_data;
        end
    end

    assign resp = '{rd_data:  pipe_q[LATENCY-1].rd_data,
                    MemWrite: pipe_q[LATENCY-1].MemWrite,
                    MemRead:  pipe_q[LATENCY-1].MemRead,
                    valid:    pipe_q[LATENCY-1].valid};

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios plus random traffic against a queue-based model.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    memReqStruct  req = '0;
    logic         req_ready;
    memRespStruct resp;
    logic         resp_ready = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic         resp_err;
`endif

    typedef struct {
        int          rem;
        logic [31:0] rd;
        logic        w;
        logic        r;
        logic        err;
    } item_t;

    item_t       q[$];
    logic [31:0] mem [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          exp_valid;
    bit          exp_ready;
    item_t       exp_head;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_ready (req_ready),
        .resp      (resp),
        .resp_ready(resp_ready)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .resp_err  (resp_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one cycle's inputs and derive the model's expectation for this cycle.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input bit w, input bit r, input bit rr, input bit rst);
        @(negedge clk);
        req.valid   = v;
        req.addr    = a;
        req.wr_data = d;
        req.MemWrite = w;
        req.MemRead  = r;
        resp_ready  = rr;
        reset       = rst;
        #1;
        exp_valid = (q.size() > 0) && (q[0].rem == 0);
        exp_ready = !(exp_valid && !rr);
        if (exp_valid) exp_head = q[0];
    endtask

    // Apply the clock edge to the model, then let the edge happen.
    task automatic advance();
        item_t it;
        int    idx;
        bit    mis;
        if (reset) begin
            q.delete();
        end else if (exp_ready) begin
            if (exp_valid) void'(q.pop_front());
            foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
            if (req.valid) begin
                idx = int'((req.addr >> 2) % DEPTH);
                mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
                mis = (req.addr % 4 != 0) && (req.MemWrite || req.MemRead);
`endif
                it.rem = int'(LAT) - 1;
                it.w   = req.MemWrite;
                it.r   = req.MemRead;
                it.err = mis;
                it.rd  = '0;
                if (!mis && req.MemWrite) mem[idx] = req.wr_data;
                else if (!mis && req.MemRead) it.rd = mem[idx];
                q.push_back(it);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            advance();
        end
    endtask

    task automatic wait_resp(input bit want_read, output bit found, output logic [31:0] rd, output int at);
        found = 0; rd = '0; at = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            if (resp.valid === 1'b1 && resp.MemRead === want_read) begin
                found = 1; rd = resp.rd_data; at = cyc;
            end
            advance();
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1, 1); advance();
        drive(0, 0, 0, 0, 0, 1, 1); advance();
        drive(0, 0, 0, 0, 0, 1, 0);
        total++; if (resp.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp.valid); end
        total++; if (resp.rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", resp.rd_data); end
        total++; if (resp.MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b want=0", resp.MemWrite); end
        total++; if (resp.MemRead !== 1'b0) begin bad++; $display("FAIL reset_memread got=%b want=0", resp.MemRead); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
`ifdef DMEM_MISALIGN_CHECK_EN
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", resp_err); end
`endif
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1, 32'(i * 4), $urandom, 1, 0, 1, 0);
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=%b want=1", i, req_ready); end
            if (exp_valid) begin
                total++; if (resp.valid !== 1'b1 || resp.MemWrite !== 1'b1 || resp.MemRead !== 1'b0 || resp.rd_data !== 32'h0) begin
                    bad++; $display("FAIL fill_resp i=%0d got v=%b w=%b r=%b d=%h want v=1 w=1 r=0 d=0",
                                    i, resp.valid, resp.MemWrite, resp.MemRead, resp.rd_data);
                end
            end
            advance();
        end
        idle(LAT + 2);
    endtask

    task automatic test_store_load();
        bit found; logic [31:0] rd; int at; int n;
        drive(1, 32'h40, 32'hDEADBEEF, 1, 0, 1, 0); advance();
        drive(1, 32'h40, 32'h0, 0, 1, 1, 0); n = cyc; advance();
        wait_resp(1, found, rd, at);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL store_load_seen got=%b want=1", found); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL store_load_data got=%h want=deadbeef", rd); end
        total++; if (at !== n + int'(LAT)) begin bad++; $display("FAIL store_load_latency got=%0d want=%0d", at, n + int'(LAT)); end
        idle(LAT + 2);
    endtask

    task automatic test_backpressure();
        logic [31:0] vals [3];
        int issued; int got; int stall_seen; bit rr;
        vals[0] = 32'hB0B0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hB0B0_0003;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + 32'(4 * i), vals[i], 1, 0, 1, 0); advance();
        end
        idle(LAT + 2);
        issued = 0; got = 0; stall_seen = 0;
        for (int t = 0; t < 20; t++) begin
            rr = (t >= 4);
            if (issued < 3) drive(1, 32'h100 + 32'(4 * issued), 0, 0, 1, rr, 0);
            else drive(0, 0, 0, 0, 0, rr, 0);
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL bp_ready t=%0d got=%b want=%b", t, req_ready, exp_ready); end
            if (!rr && resp.valid === 1'b1) begin
                stall_seen++;
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready t=%0d got=%b want=0", t, req_ready); end
                total++; if (resp.rd_data !== vals[0] || resp.MemRead !== 1'b1) begin
                    bad++; $display("FAIL bp_stable t=%0d got d=%h r=%b want d=%h r=1", t, resp.rd_data, resp.MemRead, vals[0]);
                end
            end
            if (rr && resp.valid === 1'b1) begin
                total++;
                if (got >= 3) begin bad++; $display("FAIL bp_extra got=%0d responses want=3", got + 1); end
                else if (resp.rd_data !== vals[got]) begin bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", got, resp.rd_data, vals[got]); end
                got++;
            end
            if (issued < 3 && exp_ready) issued++;
            advance();
        end
        total++; if (got !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got); end
        total++; if (stall_seen !== 4 - int'(LAT)) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=%0d", stall_seen, 4 - int'(LAT)); end
    endtask

    task automatic test_wrap();
        bit found; logic [31:0] rd; int at;
        drive(1, 32'h400, 32'h12345678, 1, 0, 1, 0); advance();
        drive(1, 32'h000, 32'h0, 0, 1, 1, 0); advance();
        wait_resp(1, found, rd, at);
        total++; if (!found || rd !== 32'h12345678) begin bad++; $display("FAIL wrap got found=%b d=%h want found=1 d=12345678", found, rd); end
        idle(LAT + 2);
    endtask

    task automatic test_reset_midflight();
        bit found; logic [31:0] rd; int at;
        drive(1, 32'h10, 32'hA5A5A5A5, 1, 0, 1, 0); advance();
        drive(1, 32'h10, 32'h0, 0, 1, 1, 0); advance();
        drive(1, 32'h10, 32'hFFFF0000, 1, 0, 1, 1); advance();
        for (int k = 0; k < int'(LAT) + 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            total++; if (resp.valid !== 1'b0) begin bad++; $display("FAIL flush_no_resp k=%0d got=%b want=0", k, resp.valid); end
            advance();
        end
        drive(1, 32'h10, 32'h0, 0, 1, 1, 0); advance();
        wait_resp(1, found, rd, at);
        total++; if (!found || rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL flush_persist got found=%b d=%h want found=1 d=a5a5a5a5", found, rd); end
        idle(LAT + 2);
    endtask

    task automatic test_misalign();
        bit found; logic [31:0] rd; int at; logic [31:0] want;
        drive(1, 32'h20, 32'hCAFEF00D, 1, 0, 1, 0); advance();
        idle(LAT + 2);
        drive(1, 32'h22, 32'h1, 1, 0, 1, 0); advance();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            if (resp.valid === 1'b1 && resp.MemWrite === 1'b1) begin
                found = 1;
                total++; if (resp.rd_data !== 32'h0) begin bad++; $display("FAIL misalign_rd got=%h want=0", resp.rd_data); end
`ifdef DMEM_MISALIGN_CHECK_EN
                total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", resp_err); end
`endif
            end
            advance();
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL misalign_seen got=%b want=1", found); end
`ifdef DMEM_MISALIGN_CHECK_EN
        want = 32'hCAFEF00D;
`else
        want = 32'h1;
`endif
        drive(1, 32'h20, 32'h0, 0, 1, 1, 0); advance();
        wait_resp(1, found, rd, at);
        total++; if (!found || rd !== want) begin bad++; $display("FAIL misalign_word got found=%b d=%h want found=1 d=%h", found, rd, want); end
        idle(LAT + 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 800; t++) begin
            drive($urandom % 5 != 0, $urandom & 32'hFFF, $urandom, $urandom % 2 == 1, $urandom % 2 == 1,
                  $urandom % 10 < 7, $urandom % 100 == 0);
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready t=%0d got=%b want=%b", t, req_ready, exp_ready); end
            total++; if (resp.valid !== exp_valid) begin bad++; $display("FAIL rand_valid t=%0d got=%b want=%b", t, resp.valid, exp_valid); end
            if (exp_valid) begin
                total++;
                if (resp.rd_data !== exp_head.rd || resp.MemWrite !== exp_head.w || resp.MemRead !== exp_head.r) begin
                    bad++; $display("FAIL rand_resp t=%0d got d=%h w=%b r=%b want d=%h w=%b r=%b", t,
                                    resp.rd_data, resp.MemWrite, resp.MemRead, exp_head.rd, exp_head.w, exp_head.r);
                end
`ifdef DMEM_MISALIGN_CHECK_EN
                total++; if (resp_err !== exp_head.err) begin bad++; $display("FAIL rand_err t=%0d got=%b want=%b", t, resp_err, exp_head.err); end
`endif
            end
            advance();
        end
        idle(LAT + 2);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
